param_updown_counter: RTL

//  Parametrised modulo-N up/down counter; next generation of the 2-bit free-running counter.

---
 rtl/param_updown_counter_pkg.sv | 15 +
 rtl/param_updown_counter.sv | 127 ++++++++++++
 2 files changed

// File: rtl/param_updown_counter_pkg.sv
// Shared definitions for the parametrised up/down counter.
//   MODE_* : count-mode selectors for the MODE parameter
//   state_e: ONESHOT run/done state encoding
package param_updown_counter_pkg;

    localparam int unsigned MODE_WRAP     = 0;
    localparam int unsigned MODE_SATURATE = 1;
    localparam int unsigned MODE_ONESHOT  = 2;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_DONE = 1'b1
    } state_e;

endpackage

// File: rtl/param_updown_counter.sv
// Modulo-MODULUS up/down counter with enable, load, clear, three end-of-range
// modes (wrap / saturate / one-shot), terminal-count and cascade outputs.
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   en, up_dn         step enable, direction (1 = up)
//   load, load_val    parallel load (clamped to MODULUS-1)
//   clear             load the direction-dependent start value
//   start             one-shot re-arm from DONE
//   count             registered count, always in 0..MODULUS-1
//   tc, cout          combinational terminal count / cascade carry-borrow
//   wrap, done        registered roll-over pulse / one-shot finished flag
module param_updown_counter
    import param_updown_counter_pkg::*;
#(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned MODULUS = 10,
    parameter int unsigned MODE    = MODE_WRAP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clear,
    input  logic             start,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             cout,
    output logic             wrap,
    output logic             done
);

    localparam logic [WIDTH:0]   MOD_X  = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH-1:0] END_HI = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] END_LO = '0;

    // Elaboration-time parameter sanity checks
    if (WIDTH < 1) begin : g_chk_width
        $error("param_updown_counter: WIDTH must be >= 1");
    end
    if ((MODULUS < 2) || (64'(MODULUS) > (64'(1) << WIDTH))) begin : g_chk_modulus
        $error("param_updown_counter: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
    end
    if (MODE > MODE_ONESHOT) begin : g_chk_mode
        $error("param_updown_counter: MODE must be 0, 1 or 2");
    end

    logic [WIDTH-1:0] count_q, count_d;
    logic             wrap_q, wrap_d;
    logic             done_q, done_d;
    state_e           state_q, state_d;

    logic [WIDTH-1:0] start_val;
    logic [WIDTH-1:0] end_val;
    logic             at_end;
    logic [WIDTH:0]   count_x;
    logic [WIDTH:0]   step_x;

    // Direction-dependent start/end values and one-step neighbour
    always_comb begin
        start_val = up_dn ? END_LO : END_HI;
        end_val   = up_dn ? END_HI : END_LO;
        at_end    = (count_q == end_val);
        count_x   = {1'b0, count_q};
        step_x    = up_dn ? (count_x + (WIDTH+1)'(1)) : (count_x - (WIDTH+1)'(1));
    end

    // Next-state: rst (in the register) > clear > load > DONE hold/start > en
    always_comb begin
        count_d = count_q;
        state_d = state_q;
        wrap_d  = 1'b0;
        if (clear) begin
            count_d = start_val;
            state_d = ST_RUN;
        end else if (load) begin
            count_d = ({1'b0, load_val} >= MOD_X) ? END_HI : load_val;
            state_d = ST_RUN;
        end else if (state_q == ST_DONE) begin
            if (start) begin
                count_d = start_val;
                state_d = ST_RUN;
            end
        end else if (en) begin
            if (at_end) begin
                // The roll-over target coincides with the start value for either direction
                if (MODE == MODE_WRAP) begin
                    count_d = start_val;
                    wrap_d  = 1'b1;
                end else if (MODE == MODE_SATURATE) begin
                    count_d = count_q;
                end else begin
                    state_d = ST_DONE;
                end
            end else begin
                count_d = step_x[WIDTH-1:0];
                if ((MODE == MODE_ONESHOT) && (step_x == {1'b0, end_val})) begin
                    state_d = ST_DONE;
                end
            end
        end
        done_d = (state_d == ST_DONE);
    end

    // State registers
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
            done_q  <= 1'b0;
            state_q <= ST_RUN;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
            done_q  <= done_d;
            state_q <= state_d;
        end
    end

    assign count = count_q;
    assign wrap  = wrap_q;
    assign done  = done_q;
    assign tc    = up_dn ? (count_q == END_HI) : (count_q == END_LO);
    assign cout  = en & tc & (state_q != ST_DONE);

endmodule
